// File: rtl/add_seq_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and nibble width.
package add_seq_ctrl_pkg;

    localparam int NIBW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_seq_ctrl_nib_add.sv
// nib_add: 4-bit adder with carry in/out; the single datapath slice reused every RUN cycle.
module nib_add
    import add_seq_ctrl_pkg::*;
(
    input  logic [NIBW-1:0] a,
    input  logic [NIBW-1:0] b,
    input  logic            cin,
    output logic [NIBW-1:0] s,
    output logic            cout
);

    // One extra bit holds the carry out of the nibble.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBW{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequential WIDTH-bit adder that reuses one nibble adder over WIDTH/4
// cycles, LSB nibble first. Optional macro ADD_SEQ_SUB_EN adds a 'sub' port that
// turns the operation into a - b (computed as a + ~b + 1, c_in ignored).
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NIB  = WIDTH / NIBW;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    // Operand width must split evenly into at least two nibbles.
    if ((WIDTH % NIBW) != 0 || WIDTH < 8) begin : g_bad_width
        $error("add_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [NIBW-1:0]  nib_s;
    logic             nib_c;

    // Operand conditioning at capture time: subtraction becomes a + ~b + 1.
`ifdef ADD_SEQ_SUB_EN
    assign op_b   = sub ? ~b : b;
    assign op_cin = sub ? 1'b1 : c_in;
`else
    assign op_b   = b;
    assign op_cin = c_in;
`endif

    nib_add u_nib_add (
        .a    (a_q[idx_q*NIBW +: NIBW]),
        .b    (b_q[idx_q*NIBW +: NIBW]),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Next-state and datapath update: capture on accepted start, one nibble per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = op_b;
                    carry_d = op_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[idx_q*NIBW +: NIBW] = nib_s;
                carry_d = nib_c;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = nib_c;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule
